// File: rtl/exp_calc_scheduler.sv
// Round-robin scheduler sharing one expression evaluator between NUM_REQ requesters.
// Accepts one job at a time, launches the evaluator, guards against hangs and returns the tagged result.
module exp_calc_scheduler #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned EXPR_W  = 400,
  parameter int unsigned RES_W   = 50,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*EXPR_W-1:0]   req_expr,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        eval_start,
  output logic [EXPR_W-1:0]           eval_expr,
  input  logic                        eval_done,
  input  logic [RES_W-1:0]            eval_result,
  input  logic                        eval_error,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [RES_W-1:0]            rsp_result,
  output logic                        rsp_error,
  output logic                        rsp_timeout,
  input  logic [NUM_REQ-1:0]          rsp_ready,
  output logic                        busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e               state_q;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [IDX_W-1:0]     grant_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [NUM_REQ-1:0]   req_ready_q;
  logic                 eval_start_q;
  logic [EXPR_W-1:0]    eval_expr_q;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic [RES_W-1:0]     rsp_result_q;
  logic                 rsp_error_q;
  logic                 rsp_timeout_q;
  logic                 busy_q;

  logic                 any_valid_c;
  logic [IDX_W-1:0]     grant_d;
  logic [IDX_W:0]       sum_c;
  logic [IDX_W-1:0]     idx_c;
  logic [IDX_W-1:0]     rr_ptr_d;

  // First pending requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    any_valid_c = 1'b0;
    grant_d     = '0;
    sum_c       = '0;
    idx_c       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      sum_c = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (sum_c >= (IDX_W+1)'(NUM_REQ)) begin
        sum_c = sum_c - (IDX_W+1)'(NUM_REQ);
      end
      idx_c = IDX_W'(sum_c);
      if (!any_valid_c && req_valid[idx_c]) begin
        any_valid_c = 1'b1;
        grant_d     = idx_c;
      end
    end
  end

  assign rr_ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

  // Sequencing FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      grant_q       <= '0;
      cnt_q         <= '0;
      req_ready_q   <= '0;
      eval_start_q  <= 1'b0;
      eval_expr_q   <= '0;
      rsp_valid_q   <= '0;
      rsp_result_q  <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      req_ready_q  <= '0;
      eval_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (any_valid_c) begin
            grant_q      <= grant_d;
            eval_expr_q  <= req_expr[32'(grant_d) * EXPR_W +: EXPR_W];
            req_ready_q  <= NUM_REQ'(1) << grant_d;
            eval_start_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // A completion landing on the timeout cycle still wins.
          if (eval_done) begin
            rsp_result_q  <= eval_result;
            rsp_error_q   <= eval_error;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= NUM_REQ'(1) << grant_q;
            state_q       <= S_RESP;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            rsp_result_q  <= '0;
            rsp_error_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= NUM_REQ'(1) << grant_q;
            state_q       <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready[grant_q]) begin
            rsp_valid_q <= '0;
            rr_ptr_q    <= rr_ptr_d;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign eval_start  = eval_start_q;
  assign eval_expr   = eval_expr_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_error   = rsp_error_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_exp_calc_scheduler.sv
// Directed bench for exp_calc_scheduler: the evaluator is played by the stimulus itself.
module tb_exp_calc_scheduler;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned EXPR_W  = 400;
  localparam int unsigned RES_W   = 50;
  localparam int unsigned TIMEOUT = 1023;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*EXPR_W-1:0] req_expr;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      eval_start;
  logic [EXPR_W-1:0]         eval_expr;
  logic                      eval_done;
  logic [RES_W-1:0]          eval_result;
  logic                      eval_error;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [RES_W-1:0]          rsp_result;
  logic                      rsp_error;
  logic                      rsp_timeout;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic                      busy;

  int unsigned total  = 0;
  int unsigned passed = 0;

  logic [119:0]      s0;
  logic [23:0]       s1;
  logic [39:0]       s2;
  logic [EXPR_W-1:0] e0, e1, e2;

  exp_calc_scheduler #(
    .NUM_REQ(NUM_REQ), .EXPR_W(EXPR_W), .RES_W(RES_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_expr(req_expr), .req_ready(req_ready),
    .eval_start(eval_start), .eval_expr(eval_expr),
    .eval_done(eval_done), .eval_result(eval_result), .eval_error(eval_error),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_error(rsp_error),
    .rsp_timeout(rsp_timeout), .rsp_ready(rsp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [EXPR_W-1:0] obs, input logic [EXPR_W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".req_ready"}, EXPR_W'(req_ready), '0);
    chk({tag, ".eval_start"}, EXPR_W'(eval_start), '0);
    chk({tag, ".eval_expr"}, eval_expr, '0);
    chk({tag, ".rsp_valid"}, EXPR_W'(rsp_valid), '0);
    chk({tag, ".rsp_result"}, EXPR_W'(rsp_result), '0);
    chk({tag, ".rsp_error"}, EXPR_W'(rsp_error), '0);
    chk({tag, ".rsp_timeout"}, EXPR_W'(rsp_timeout), '0);
    chk({tag, ".busy"}, EXPR_W'(busy), '0);
  endtask

  // Accept edge then the ISSUE->WAIT edge.
  task automatic accept(input string tag, input logic [NUM_REQ-1:0] exp_rdy, input logic [EXPR_W-1:0] exp_expr);
    tick();
    chk({tag, ".req_ready"}, EXPR_W'(req_ready), EXPR_W'(exp_rdy));
    chk({tag, ".eval_start"}, EXPR_W'(eval_start), EXPR_W'(1));
    chk({tag, ".eval_expr"}, eval_expr, exp_expr);
    chk({tag, ".busy"}, EXPR_W'(busy), EXPR_W'(1));
    tick();
    chk({tag, ".start_pulse"}, EXPR_W'(eval_start), '0);
    chk({tag, ".ready_pulse"}, EXPR_W'(req_ready), '0);
  endtask

  task automatic finish(input string tag, input int unsigned dly, input logic [RES_W-1:0] res,
                        input logic err, input logic [NUM_REQ-1:0] exp_vld);
    repeat (dly) tick();
    chk({tag, ".no_early_rsp"}, EXPR_W'(rsp_valid), '0);
    eval_done   = 1'b1;
    eval_result = res;
    eval_error  = err;
    tick();
    eval_done   = 1'b0;
    eval_error  = 1'b0;
    chk({tag, ".rsp_valid"}, EXPR_W'(rsp_valid), EXPR_W'(exp_vld));
    chk({tag, ".rsp_result"}, EXPR_W'(rsp_result), EXPR_W'(res));
    chk({tag, ".rsp_error"}, EXPR_W'(rsp_error), EXPR_W'(err));
    chk({tag, ".rsp_timeout"}, EXPR_W'(rsp_timeout), '0);
  endtask

  task automatic release_rsp(input string tag, input logic [NUM_REQ-1:0] rdy);
    rsp_ready = rdy;
    tick();
    rsp_ready = '0;
    chk({tag, ".rsp_cleared"}, EXPR_W'(rsp_valid), '0);
    chk({tag, ".busy_low"}, EXPR_W'(busy), '0);
  endtask

  initial begin
    s0 = "(((7+3)*5)+8)*2";
    s1 = "9-7";
    s2 = "3*5-0";
    e0 = {s0, 280'd0};
    e1 = {s1, 376'd0};
    e2 = {s2, 360'd0};
    rst = 1'b1; req_valid = '0; req_expr = '0; eval_done = 1'b0;
    eval_result = '0; eval_error = 1'b0; rsp_ready = '0;
    tick(); tick();
    rst = 1'b0;
    chk_idle_outputs("reset");

    // Single job from requester 0.
    req_valid = 2'b01;
    req_expr[0 +: EXPR_W] = e0;
    accept("job1", 2'b01, e0);
    req_valid = '0;
    finish("job1", 4, 50'd116, 1'b0, 2'b01);
    chk("job1.busy_resp", EXPR_W'(busy), EXPR_W'(1));
    release_rsp("job1", 2'b01);

    // Completion pulse while idle must be ignored.
    eval_done = 1'b1; eval_result = 50'd77;
    tick();
    eval_done = 1'b0;
    chk("idle_done.busy", EXPR_W'(busy), '0);
    chk("idle_done.rsp_valid", EXPR_W'(rsp_valid), '0);

    // Contention with both requesters held; reset first so rr_ptr starts at 0.
    rst = 1'b1; tick(); rst = 1'b0;
    req_valid = 2'b11;
    req_expr[0 +: EXPR_W] = e2;
    req_expr[EXPR_W +: EXPR_W] = e1;
    accept("cont0", 2'b01, e2);
    finish("cont0", 1, 50'd7, 1'b0, 2'b01);
    release_rsp("cont0", 2'b01);
    accept("cont1", 2'b10, e1);
    finish("cont1", 0, 50'h3_FFFF_FFFF_FEB2, 1'b0, 2'b10);
    release_rsp("cont1", 2'b10);
    accept("cont2", 2'b01, e2);
    req_valid = '0;
    finish("cont2", 2, 50'd15, 1'b0, 2'b01);
    release_rsp("cont2", 2'b01);

    // Negative result from requester 1, then an error job from requester 0.
    req_valid = 2'b10;
    accept("neg", 2'b10, e1);
    req_valid = '0;
    finish("neg", 3, 50'h3_FFFF_FFFF_FF07, 1'b0, 2'b10);
    chk("neg.sign_bit", EXPR_W'(rsp_result[RES_W-1]), EXPR_W'(1));
    release_rsp("neg", 2'b10);
    req_valid = 2'b01;
    accept("err", 2'b01, e2);
    req_valid = '0;
    finish("err", 2, 50'd5, 1'b1, 2'b01);
    release_rsp("err", 2'b01);

    // Timeout: no completion for TIMEOUT cycles in WAIT.
    req_valid = 2'b01;
    eval_result = 50'd99;
    accept("tmo", 2'b01, e2);
    req_valid = '0;
    repeat (TIMEOUT - 1) tick();
    chk("tmo.still_waiting", EXPR_W'(rsp_valid), '0);
    chk("tmo.busy", EXPR_W'(busy), EXPR_W'(1));
    tick();
    chk("tmo.rsp_valid", EXPR_W'(rsp_valid), EXPR_W'(2'b01));
    chk("tmo.rsp_result", EXPR_W'(rsp_result), '0);
    chk("tmo.rsp_error", EXPR_W'(rsp_error), EXPR_W'(1));
    chk("tmo.rsp_timeout", EXPR_W'(rsp_timeout), EXPR_W'(1));
    eval_done = 1'b1; eval_result = 50'd55;
    tick();
    eval_done = 1'b0;
    chk("tmo.late_result", EXPR_W'(rsp_result), '0);
    chk("tmo.late_timeout", EXPR_W'(rsp_timeout), EXPR_W'(1));
    chk("tmo.late_valid", EXPR_W'(rsp_valid), EXPR_W'(2'b01));
    release_rsp("tmo", 2'b01);

    // Back-pressure on requester 0 while requester 1 is pending and pulls its own rsp_ready.
    req_valid = 2'b01;
    accept("bp", 2'b01, e2);
    req_valid = '0;
    finish("bp", 1, 50'd42, 1'b0, 2'b01);
    req_valid = 2'b10;
    rsp_ready = 2'b10;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp.rsp_valid", EXPR_W'(rsp_valid), EXPR_W'(2'b01));
      chk("bp.rsp_result", EXPR_W'(rsp_result), EXPR_W'(42));
      chk("bp.no_accept", EXPR_W'(req_ready), '0);
    end
    release_rsp("bp", 2'b01);

    // Reset in the middle of WAIT, then rr_ptr must be back at 0.
    accept("rstjob", 2'b10, e1);
    tick(); tick();
    req_valid = '0;
    rst = 1'b1; tick(); rst = 1'b0;
    chk_idle_outputs("midreset");
    req_valid = 2'b11;
    accept("post0", 2'b01, e2);
    req_valid = 2'b10;
    finish("post0", 1, 50'd3, 1'b0, 2'b01);
    release_rsp("post0", 2'b01);
    accept("post1", 2'b10, e1);
    req_valid = '0;
    finish("post1", 2, 50'd2, 1'b0, 2'b10);
    release_rsp("post1", 2'b10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
